// File: rtl/l2_mp_trace_collector.sv
// MainPipe stage-3 task trace collector: filters events, stamps them with a free-running
// cycle count and buffers them in a FIFO toward the trace writer, counting overflow drops.
module l2_mp_trace_collector #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [1:0]               in_metaWway,
    input  logic                     in_metaWvalid,
    input  logic [7:0]               in_mshrId,
    input  logic [7:0]               in_allocPtr,
    input  logic                     in_allocValid,
    input  logic [1:0]               in_dirWay,
    input  logic                     in_dirHit,
    input  logic [6:0]               in_sset,
    input  logic [7:0]               in_tag,
    input  logic [2:0]               in_opcode,
    input  logic [2:0]               in_channel,
    input  logic                     in_mshrTask,
    input  logic                     trace_en,
    input  logic [2:0]               chan_mask,
    input  logic                     out_ready,
    output logic                     out_en,
    output logic [1:0]               out_metaWway,
    output logic                     out_metaWvalid,
    output logic [7:0]               out_mshrId,
    output logic [7:0]               out_allocPtr,
    output logic                     out_allocValid,
    output logic [1:0]               out_dirWay,
    output logic                     out_dirHit,
    output logic [6:0]               out_sset,
    output logic [7:0]               out_tag,
    output logic [2:0]               out_opcode,
    output logic [2:0]               out_channel,
    output logic                     out_mshrTask,
    output logic [63:0]              out_stamp,
    output logic [15:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = 45;
    localparam int unsigned EW = PW + 64;
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [63:0]   stamp_q, stamp_d;
    logic [15:0]   drop_q, drop_d;

    logic [PW-1:0] in_payload;
    logic [EW-1:0] head;
    logic          capture, full, pop, push, drop;

    assign in_payload = {in_metaWway, in_metaWvalid, in_mshrId, in_allocPtr, in_allocValid,
                         in_dirWay, in_dirHit, in_sset, in_tag, in_opcode, in_channel,
                         in_mshrTask};

    assign capture = in_valid && trace_en && ((in_channel & chan_mask) != 3'b000);
    assign full    = (occ_q == FullCnt);
    assign pop     = out_en && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        stamp_d  = stamp_q + 64'd1;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - (AW + 1)'(1);
        end
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            stamp_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            stamp_q  <= stamp_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= {stamp_q, in_payload};
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_en    = (occ_q != '0);
    assign out_stamp = head[EW-1:PW];
    assign {out_metaWway, out_metaWvalid, out_mshrId, out_allocPtr, out_allocValid,
            out_dirWay, out_dirHit, out_sset, out_tag, out_opcode, out_channel,
            out_mshrTask} = head[PW-1:0];
    assign drop_cnt  = drop_q;
    assign occupancy = occ_q;

endmodule
